// File: rtl/dtc_share_sched.sv
// dtc_share_sched: round-robin scheduler sharing one external decision-tree
// classifier between two feature-vector requesters (A, B).
//
// A granted feature vector is registered onto cls_feat. The scheduler then waits
// CLS_LAT cycles and samples cls_class. It tags the class with the source id and
// pushes it into a small result FIFO. At most one sample is in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a_valid/a_feat      requester A request; a_ready is combinational accept
//   b_valid/b_feat      requester B request; b_ready is combinational accept
//   cls_feat            registered feature vector driven to the classifier
//   cls_class           classifier result
//   out_valid/out_class/out_src/out_ready   result FIFO head (src 0=A, 1=B)
//   busy                evaluation in progress (EVAL or WRITE)
//   cnt_a/cnt_b         completed samples per source
//
// Optional feature: define DTC_SCHED_STATS_EN to enable saturating 16-bit
// completion counters. Without it, cnt_a/cnt_b are tied to 0.
module dtc_share_sched #(
   parameter int unsigned FEAT_W     = 9,
   parameter int unsigned CLS_W      = 5,
   parameter int unsigned CLS_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [FEAT_W-1:0] a_feat,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [FEAT_W-1:0] b_feat,
   output logic              b_ready,
   output logic [FEAT_W-1:0] cls_feat,
   input  logic [CLS_W-1:0]  cls_class,
   output logic              out_valid,
   output logic [CLS_W-1:0]  out_class,
   output logic              out_src,
   input  logic              out_ready,
   output logic              busy,
   output logic [15:0]       cnt_a,
   output logic [15:0]       cnt_b
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAT_W = 4;

   typedef struct packed {
      logic             src;
      logic [CLS_W-1:0] cls;
   } ent_t;

   typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [FEAT_W-1:0] feat_q, feat_d;
   logic              src_q, src_d;
   logic              last_q, last_d;
   logic [CLS_W-1:0]  hold_q, hold_d;
   logic              busy_q, busy_d;
   logic              push;

   ent_t              mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  count_q, count_d;
   ent_t              head_q, head_d, push_ent;
   logic              valid_q, valid_d;
   logic              pop;
   logic              space, win_a, win_b;

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   assign space = (count_q < CNT_W'(FIFO_DEPTH));
   assign win_a = a_valid && (!b_valid || last_q);
   assign win_b = b_valid && (!a_valid || !last_q);

   // Scheduler next-state and handshake logic.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      feat_d  = feat_q;
      src_d   = src_q;
      last_d  = last_q;
      hold_d  = hold_q;
      busy_d  = busy_q;
      a_ready = 1'b0;
      b_ready = 1'b0;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (space) begin
               a_ready = win_a;
               b_ready = win_b;
            end
            if (a_ready) begin
               feat_d  = a_feat;
               src_d   = 1'b0;
               last_d  = 1'b0;
               lat_d   = LAT_W'(CLS_LAT);
               busy_d  = 1'b1;
               state_d = EVAL;
            end else if (b_ready) begin
               feat_d  = b_feat;
               src_d   = 1'b1;
               last_d  = 1'b1;
               lat_d   = LAT_W'(CLS_LAT);
               busy_d  = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL: begin
            lat_d = lat_q - LAT_W'(1);
            // Counter reaching zero marks the CLS_LAT-th cycle after cls_feat changed.
            if (lat_q == LAT_W'(1)) begin
               hold_d  = cls_class;
               state_d = WRITE;
            end
         end
         WRITE: begin
            push    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Result FIFO bookkeeping; the head is kept in registers so out_* are flops.
   always_comb begin
      pop          = valid_q && out_ready;
      push_ent.src = src_q;
      push_ent.cls = hold_q;
      wr_d         = push ? wr_q + PTR_W'(1) : wr_q;
      rd_d         = pop  ? rd_q + PTR_W'(1) : rd_q;
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      valid_d      = (count_d != CNT_W'(0));
      // The pushed entry becomes the head when nothing older survives this cycle.
      if (push && ((count_q == CNT_W'(0)) || (pop && (count_q == CNT_W'(1))))) begin
         head_d = push_ent;
      end else begin
         head_d = mem[rd_d];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lat_q   <= '0;
         feat_q  <= '0;
         src_q   <= 1'b0;
         last_q  <= 1'b1;
         hold_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         feat_q  <= feat_d;
         src_q   <= src_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end

   // FIFO storage, pointers and head registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_q] <= push_ent;
         end
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= valid_d;
      end
   end

   assign cls_feat  = feat_q;
   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_class = head_q.cls;
   assign out_src   = head_q.src;

`ifdef DTC_SCHED_STATS_EN
   logic [15:0] cnt_a_q, cnt_b_q;

   // Saturating per-source completion counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else if (push) begin
         if (!src_q && (cnt_a_q != 16'hFFFF)) begin
            cnt_a_q <= cnt_a_q + 16'd1;
         end
         if (src_q && (cnt_b_q != 16'hFFFF)) begin
            cnt_b_q <= cnt_b_q + 16'd1;
         end
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`else
   assign cnt_a = '0;
   assign cnt_b = '0;
`endif

endmodule

// File: doc/dtc_share_sched.md
Name: dtc_share_sched

Overview:
- Round-robin scheduler that shares one decision-tree classifier instance between two feature-vector requesters (A, B).
- Registers the granted 9-bit feature vector onto the classifier input and waits a fixed evaluation latency.
- Captures the 5-bit class code, tags it with the source id, and buffers it in a small result FIFO with a valid/ready output.
- Sits between the sample producers and the classifier; the classifier itself is external.

Parameters:
- FEAT_W, 9, feature vector width.
- CLS_W, 5, class code width.
- CLS_LAT, 1, cycles from cls_feat update to cls_class sample point; range 1..15.
- FIFO_DEPTH, 4, result FIFO entries; power of two, range 2..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a feature vector.
- a_feat  in  FEAT_W  requester A feature vector.
- a_ready  out  1  A handshake accept.
- b_valid  in  1  requester B has a feature vector.
- b_feat  in  FEAT_W  requester B feature vector.
- b_ready  out  1  B handshake accept.
- cls_feat  out  FEAT_W  registered feature vector driven to the classifier.
- cls_class  in  CLS_W  classifier result.
- out_valid  out  1  FIFO head valid.
- out_class  out  CLS_W  FIFO head class code.
- out_src  out  1  FIFO head source; 0 = A, 1 = B.
- out_ready  in  1  consumer accept.
- busy  out  1  classifier evaluation in progress.
- cnt_a  out  16  samples completed for A (see Optional Feature).
- cnt_b  out  16  samples completed for B (see Optional Feature).

Behaviour:
- Reset: clk/rst_n only; reset is asynchronous and active-low. All registers clear: state=IDLE, cls_feat=0, busy=0, out_valid=0, out_class=0, out_src=0, FIFO empty, cnt_a=cnt_b=0, last_grant=B (so A wins the first tie).
- FSM states IDLE, EVAL, WRITE. One sample in flight at most.
- IDLE:
  - a_ready/b_ready are combinational and high only in IDLE, with FIFO count < FIFO_DEPTH, and to the arbitration winner; never both high.
  - Arbitration: if only one valid, it wins. If both valid, the requester not equal to last_grant wins.
  - Handshake (valid && ready) registers the feature into cls_feat, records src, updates last_grant, loads the latency counter with CLS_LAT, and moves to EVAL. busy is high from the next cycle.
- EVAL: counter decrements each cycle. When it reaches 0, sample cls_class into a holding register and go to WRITE.
  - cls_class is therefore sampled exactly CLS_LAT cycles after the cycle in which cls_feat changed.
- WRITE:
  - Push {src, class} into the FIFO, clear busy, return to IDLE.
  - Space is guaranteed because the grant was gated on count < depth, and no other pushes occur.
- Throughput: 1 sample per CLS_LAT+2 cycles.
- Holding behaviour: cls_feat holds its value after the evaluation until the next grant.
- FIFO:
  - out_* reflect the head; out_valid = (count != 0).
  - Pop on out_valid && out_ready.
  - A push and a pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
  - out_class/out_src are don't-care when out_valid=0 but must not be X after reset.
- Backpressure: while count == FIFO_DEPTH, no grants occur and requesters stall. The in-flight sample always completes.
- Requester rule: a requester may drop valid without a handshake; the scheduler holds no state for it.
- Reset mid-operation: an asynchronous assert aborts EVAL/WRITE immediately; the in-flight result is discarded and the FIFO is emptied.

Optional Feature:
- Macro: DTC_SCHED_STATS_EN.
- Defined:
  - cnt_a/cnt_b increment on each WRITE push for the respective source.
  - Counters saturate at 0xFFFF (no wrap) and clear only on reset.
- Undefined:
  - cnt_a/cnt_b are constant 0 and no counter flops are synthesized.
  - All other behaviour is identical.

Test Plan:
- Single sample: A sends 9'h155, classifier model returns 5'b10110, CLS_LAT=1, out_ready=1.
  - -> cls_feat=9'h155 the cycle after handshake.
  - -> out_valid rises 3 cycles after handshake with out_class=5'b10110, out_src=0.
- Contention: a_valid and b_valid held high for 4 grants.
  - -> grant order A,B,A,B.
  - -> out_src sequence 0,1,0,1; a_ready and b_ready never high together.
- Backpressure: out_ready=0, FIFO_DEPTH=4, A streams continuously.
  - -> exactly 4 results buffered, a_ready stays 0.
  - -> after one out_ready pulse, one more grant occurs and count returns to 4.
- Simultaneous push/pop: count=2, out_ready=1 during a WRITE cycle.
  - -> count stays 2, head advances, order preserved.
- Reset mid-EVAL (CLS_LAT=3): assert rst_n=0 on the 2nd EVAL cycle.
  - -> busy=0, out_valid=0, cls_feat=0 immediately; after release, A wins the first tie.
- Stats (DTC_SCHED_STATS_EN defined): 3 A and 2 B completions -> cnt_a=3, cnt_b=2.
  - With the macro undefined, both read 0.
